// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB full-speed transmit encoder.
// Line encodings are {d_plus, d_minus}.
package usb_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        STUFF,
        EOP_SE0,
        EOP_J
    } tx_state_t;

    localparam logic [1:0] LINE_J   = 2'b10;
    localparam logic [1:0] LINE_K   = 2'b01;
    localparam logic [1:0] LINE_SE0 = 2'b00;

    localparam logic [2:0] STUFF_LIMIT  = 3'd6;
    localparam int         EOP_SE0_BITS = 2;

    // NRZI transition used for a data 0 and for a stuffed bit.
    function automatic logic [1:0] nrzi_toggle(input logic [1:0] line);
        return (line == LINE_J) ? LINE_K : LINE_J;
    endfunction

endpackage

// File: rtl/tx_byte_buffer.sv
// Small synchronous FIFO with fall-through read data. A write while full
// is accepted only when a read retires an entry in the same cycle.
module tx_byte_buffer #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             do_rd;
    logic             do_wr;

    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = mem[rd_ptr_reg];

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_wr) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_rd) rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr_reg] <= wr_data;
    end

endmodule

// File: rtl/usb_tx_encoder.sv
// USB full-speed transmitter: buffered bytes are serialised LSB first,
// bit-stuffed, NRZI encoded onto D+/D-, and closed with an SE0,SE0,J EOP.
module usb_tx_encoder
    import usb_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4,
    parameter int BUF_DEPTH    = 2
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [7:0] tx_byte,
    input  logic       tx_byte_valid,
    input  logic       tx_eop_req,
    input  logic       clear_err,
    output logic       tx_ready,
    output logic       tx_active,
    output logic       d_plus,
    output logic       d_minus,
    output logic       overrun,
    output logic       underrun
);

    localparam int TW = $clog2(CLKS_PER_BIT);

    tx_state_t state_reg, state_next;
    logic [TW-1:0] tmr_reg, tmr_next;
    logic [7:0]    shift_reg, shift_next;
    logic [2:0]    bit_idx_reg, bit_idx_next;
    logic [2:0]    ones_reg, ones_next;
    logic [1:0]    line_reg, line_next;
    logic          active_reg, active_next;
    logic          eop_pending_reg, eop_pending_next;
    logic          overrun_reg, overrun_next;
    logic          underrun_reg, underrun_next;

    logic       pop;
    logic       boundary;
    logic       underrun_set;
    logic       eop_clear;
    logic       bit_start;
    logic       bit_end;
    logic [2:0] ones_inc;
    logic [7:0] buf_data;
    logic       buf_full;
    logic       buf_empty;

    tx_byte_buffer #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (8)
    ) u_buf (
        .clk     (clk),
        .n_rst   (n_rst),
        .wr_en   (tx_byte_valid),
        .wr_data (tx_byte),
        .rd_en   (pop),
        .rd_data (buf_data),
        .full    (buf_full),
        .empty   (buf_empty)
    );

    assign bit_start = (tmr_reg == '0);
    assign bit_end   = (tmr_reg == TW'(CLKS_PER_BIT - 1));
    assign ones_inc  = shift_reg[0] ? (ones_reg + 3'd1) : 3'd0;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_reg       <= IDLE;
            tmr_reg         <= '0;
            shift_reg       <= '0;
            bit_idx_reg     <= '0;
            ones_reg        <= '0;
            line_reg        <= LINE_J;
            active_reg      <= 1'b0;
            eop_pending_reg <= 1'b0;
            overrun_reg     <= 1'b0;
            underrun_reg    <= 1'b0;
        end else begin
            state_reg       <= state_next;
            tmr_reg         <= tmr_next;
            shift_reg       <= shift_next;
            bit_idx_reg     <= bit_idx_next;
            ones_reg        <= ones_next;
            line_reg        <= line_next;
            active_reg      <= active_next;
            eop_pending_reg <= eop_pending_next;
            overrun_reg     <= overrun_next;
            underrun_reg    <= underrun_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        tmr_next     = '0;
        shift_next   = shift_reg;
        bit_idx_next = bit_idx_reg;
        ones_next    = ones_reg;
        line_next    = line_reg;
        active_next  = active_reg;
        pop          = 1'b0;
        boundary     = 1'b0;
        underrun_set = 1'b0;
        eop_clear    = 1'b0;

        if (state_reg != IDLE) tmr_next = bit_end ? '0 : tmr_reg + 1'b1;

        // Line updates on the first cycle of each bit; decisions on the last.
        case (state_reg)
            IDLE: begin
                if (!buf_empty) begin
                    pop          = 1'b1;
                    shift_next   = buf_data;
                    bit_idx_next = '0;
                    ones_next    = '0;
                    line_next    = LINE_J;
                    active_next  = 1'b1;
                    state_next   = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_start) line_next = shift_reg[0] ? line_reg : nrzi_toggle(line_reg);
                if (bit_end) begin
                    ones_next    = ones_inc;
                    shift_next   = {1'b0, shift_reg[7:1]};
                    bit_idx_next = bit_idx_reg + 1'b1;
                    if (ones_inc == STUFF_LIMIT) state_next = STUFF;
                    else if (bit_idx_reg == 3'd7) boundary = 1'b1;
                end
            end
            STUFF: begin
                if (bit_start) line_next = nrzi_toggle(line_reg);
                if (bit_end) begin
                    ones_next = '0;
                    // Bit index already wrapped to 0 when the stuff followed bit 7.
                    if (bit_idx_reg == 3'd0) boundary = 1'b1;
                    else state_next = SHIFT;
                end
            end
            EOP_SE0: begin
                if (bit_start) line_next = LINE_SE0;
                if (bit_end) begin
                    if (bit_idx_reg == 3'(EOP_SE0_BITS - 1)) state_next = EOP_J;
                    else bit_idx_next = bit_idx_reg + 1'b1;
                end
            end
            EOP_J: begin
                if (bit_start) line_next = LINE_J;
                if (bit_end) begin
                    active_next = 1'b0;
                    state_next  = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        if (boundary) begin
            if (!buf_empty) begin
                pop          = 1'b1;
                shift_next   = buf_data;
                bit_idx_next = '0;
                state_next   = SHIFT;
            end else begin
                bit_idx_next = '0;
                eop_clear    = 1'b1;
                underrun_set = !eop_pending_reg;
                state_next   = EOP_SE0;
            end
        end
    end

    // A request still held while the EOP is on the line belongs to the packet
    // being closed, so it must not arm an EOP for the next packet.
    always_comb begin
        eop_pending_next = eop_pending_reg;
        if (eop_clear)
            eop_pending_next = 1'b0;
        else if (tx_eop_req && (active_reg || !buf_empty) &&
                 state_reg != EOP_SE0 && state_reg != EOP_J)
            eop_pending_next = 1'b1;

        overrun_next = overrun_reg;
        if (clear_err) overrun_next = 1'b0;
        else if (tx_byte_valid && buf_full && !pop) overrun_next = 1'b1;

        underrun_next = underrun_reg;
        if (clear_err) underrun_next = 1'b0;
        else if (underrun_set) underrun_next = 1'b1;
    end

    assign tx_ready  = !buf_full;
    assign tx_active = active_reg;
    assign d_plus    = line_reg[1];
    assign d_minus   = line_reg[0];
    assign overrun   = overrun_reg;
    assign underrun  = underrun_reg;

endmodule
